// File: rtl/mult_div_unit_if.sv
// Operand, command and result bundle between execute-stage control and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             start;
    logic             hiwr;
    logic             lowr;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output a, b, op, start, hiwr, lowr,
        input  hi, lo, busy, done
    );

    modport slave (
        input  a, b, op, start, hiwr, lowr,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 33-cycle multiply/divide unit owning the HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in the final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH-1:0]   aRaw_q, aRaw_d;
    logic               isDiv_q, isDiv_d;
    logic               negMain_q, negMain_d;
    logic               negRem_q, negRem_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               isSigned;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     remShift;
    logic [WIDTH-1:0]   remDiff;
    logic               remFits;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == LAST_ITER) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_q == FIN);
    end

    always_comb begin
        isSigned = ~bus.op[0];
        absA     = (isSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        absB     = (isSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Multiply: opA is the multiplicand, opB shifts right as the multiplier.
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opB_q[0] ? opA_q : '0)};

        // Divide: opA shifts the dividend out MSB-first, opB is the divisor.
        remShift = {acc_q[2*WIDTH-1:WIDTH], opA_q[WIDTH-1]};
        remFits  = (remShift >= {1'b0, opB_q});
        remDiff  = remShift[WIDTH-1:0] - opB_q;

        prodFix  = negMain_q ? -acc_q : acc_q;
        quotFix  = negMain_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remFix   = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        aRaw_d    = aRaw_q;
        isDiv_d   = isDiv_q;
        negMain_d = negMain_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    isDiv_d   = bus.op[1];
                    opA_d     = absA;
                    opB_d     = absB;
                    aRaw_d    = bus.a;
                    negMain_d = isSigned & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    negRem_d  = isSigned & bus.a[WIDTH-1];
                    divZero_d = (bus.b == '0);
                    cnt_d     = '0;
                    acc_d     = '0;
                end else begin
                    if (bus.hiwr) hi_d = bus.a;
                    if (bus.lowr) lo_d = bus.a;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (isDiv_q) begin
                    acc_d = {(remFits ? remDiff : remShift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], remFits};
                    opA_d = opA_q << 1;
                end else begin
                    acc_d = {mulSum, acc_q[WIDTH-1:1]};
                    opB_d = opB_q >> 1;
                end
            end
            FIN: begin
                if (!isDiv_q) begin
                    {hi_d, lo_d} = prodFix;
                end else if (divZero_q) begin
                    hi_d = aRaw_q;
                    lo_d = '1;
                end else begin
                    hi_d = remFix;
                    lo_d = quotFix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            aRaw_q    <= '0;
            isDiv_q   <= 1'b0;
            negMain_q <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            aRaw_q    <= aRaw_d;
            isDiv_q   <= isDiv_d;
            negMain_q <= negMain_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
